// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit/receive blocks
//   tx_state_t     transmit FSM states
//   IDLE_LEVEL     level of the serial line between frames
//   MIN/MAX_DATA_BITS  legal payload widths
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_t;
    localparam logic IDLE_LEVEL    = 1'b1;
    localparam int   MIN_DATA_BITS = 5;
    localparam int   MAX_DATA_BITS = 9;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer; latches the divisor on load and ticks on the last clock of each bit
//   clk, rst   clock, synchronous active-high reset
//   load       frame start: latch max(div,1) as the bit period and restart the count
//   run        count while a frame is in progress
//   div        clocks per bit (0 behaves as 1)
//   bit_tick   high on the last clock of the current bit period
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);
    logic [DIV_W-1:0] reload, period, cnt;
    assign reload   = (div == '0) ? '0 : div - DIV_W'(1);
    assign bit_tick = run && (cnt == '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= '0;
            cnt    <= '0;
        end else if (load) begin
            period <= reload;
            cnt    <= reload;
        end else if (run) begin
            cnt <= bit_tick ? period : cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: configurable UART transmitter with a one-word holding register, LSB first
//   clk, rst    clock, synchronous active-high reset
//   tx_start    load request, accepted only while tx_ready
//   tx_data     word captured on an accepted tx_start
//   baud_div    clocks per bit, sampled at frame start (0 behaves as 1)
//   stop2       two stop bits when set, sampled at frame start
//   parity_odd  odd parity when set, sampled at frame start (only with UART_TX_PARITY_EN)
//   tx          serial line, idle high
//   tx_ready    holding register empty
//   tx_busy     frame in progress or holding register full
//   tx_done     one-cycle pulse on the last clock of the last stop bit
//   tx_overrun  one-cycle pulse after a tx_start seen while not ready
// Define UART_TX_PARITY_EN to add the parity bit and the parity_odd port.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_overrun
);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] hold, shift;
    logic [CW-1:0]        bit_cnt;
    logic                 hold_valid, stop2_l, bit_tick, frame_start;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (frame_start),
        .run      (state != IDLE),
        .div      (baud_div),
        .bit_tick (bit_tick)
    );

    assign tx_ready    = !hold_valid;
    assign tx_busy     = (state != IDLE) || hold_valid;
    assign tx_done     = bit_tick && ((state == STOP1 && !stop2_l) || state == STOP2);
    // a held word starts on the very edge the previous frame ends, so back-to-back frames have no gap
    assign frame_start = hold_valid && (state == IDLE || tx_done);

    always_comb begin
        tx = (state == START) ? ~IDLE_LEVEL :
             (state == DATA)  ? shift[0] :
`ifdef UART_TX_PARITY_EN
             (state == PARITY) ? par_bit :
`endif
             IDLE_LEVEL;
    end

    always_comb begin
        state_n = state;
        case (state)
            START:   if (bit_tick) state_n = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:    if (bit_tick && bit_cnt == LAST_BIT) state_n = PARITY;
`else
            DATA:    if (bit_tick && bit_cnt == LAST_BIT) state_n = STOP1;
`endif
            PARITY:  if (bit_tick) state_n = STOP1;
            STOP1:   if (bit_tick && stop2_l) state_n = STOP2;
            default: ;
        endcase
        if (tx_done) state_n = IDLE;
        if (frame_start) state_n = START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop2_l    <= 1'b0;
            tx_overrun <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            tx_overrun <= tx_start && hold_valid;
            // accept and consume never coincide: consuming needs hold_valid, accepting needs it clear
            if (tx_start && !hold_valid) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
            end else if (frame_start) begin
                hold_valid <= 1'b0;
            end
            if (frame_start) begin
                shift   <= hold;
                bit_cnt <= '0;
                stop2_l <= stop2;
`ifdef UART_TX_PARITY_EN
                par_bit <= (^hold) ^ parity_odd;
`endif
            end else if (bit_tick && state == DATA) begin
                shift   <= shift >> 1;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame (table vectors, corner sequences, random frames vs a waveform model)
module tb_uart_tx_frame;
    localparam int DB = 8;
    localparam int DW = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [DB-1:0] d;
        logic [DW-1:0] div;
        logic          s2;
        int            len;
        int            len_par;
    } vec_t;

    logic          clk = 1'b0, rst = 1'b1, tx_start = 1'b0, stop2 = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic [DW-1:0] baud_div = 16'd4;
`ifdef UART_TX_PARITY_EN
    logic          parity_odd = 1'b0;
`endif
    logic          tx, tx_ready, tx_busy, tx_done, tx_overrun;

    int            compared = 0, failed = 0, cyc = 0, n_done = 0;
    int            fall_cyc = 0, done_cyc = 0, acc_cyc = 0;
    bit            in_frame = 0;
    logic          par_tx = 1'b0;
    logic [DB-1:0] exp_q[$];
    int            done_hist[$], fall_hist[$];
    vec_t          tbl[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.DATA_BITS(DB), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .baud_div   (baud_div),
        .stop2      (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overrun (tx_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is the bit list {0, data LSB first, [parity], 1, [1]},
    // each bit held for P clocks; tx_done is expected only on the frame's last clock.
    initial begin : monitor
        int            i, nb, p, e_i;
        logic          bits[0:15];
        logic [DB-1:0] d;
        bit            ferr;
        logic [1:0]    e_act, e_exp;
        i = 0; nb = 1; p = 1; d = '0; ferr = 0; e_i = 0; e_act = '0; e_exp = '0;
        for (int k = 0; k < 16; k++) bits[k] = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                in_frame = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL unexpected_frame: tx fell at cycle %0d, expected no frame", cyc);
                        d = '0;
                    end else begin
                        d = exp_q.pop_front();
                    end
                    p  = (baud_div == '0) ? 1 : int'(baud_div);
                    nb = 2 + DB + PB + (stop2 ? 1 : 0);
                    for (int k = 0; k < 16; k++) bits[k] = 1'b1;
                    bits[0] = 1'b0;
                    for (int k = 0; k < DB; k++) bits[1+k] = d[k];
`ifdef UART_TX_PARITY_EN
                    bits[1+DB] = parity_odd ? ~^d : ^d;
`endif
                    i = 0; ferr = 0; in_frame = 1; fall_cyc = cyc; fall_hist.push_back(cyc);
                end
                if (in_frame) begin
                    if (!ferr && (tx !== bits[i/p] || tx_done !== (i == nb*p-1))) begin
                        ferr = 1; e_i = i; e_act = {tx, tx_done}; e_exp = {bits[i/p], i == nb*p-1};
                    end
                    if (i == (1+DB)*p) par_tx = tx;
                    if (i == nb*p-1) begin
                        compared++;
                        if (ferr) begin
                            failed++;
                            $display("FAIL frame_wave: word %h P=%0d at frame clk %0d got {tx,done}=%b expected %b", d, p, e_i, e_act, e_exp);
                        end
                        done_cyc = cyc; done_hist.push_back(cyc); n_done++; in_frame = 0;
                    end else begin
                        i++;
                    end
                end else if (tx !== 1'b1 || tx_done !== 1'b0) begin
                    compared++; failed++;
                    $display("FAIL idle_line: got tx=%b done=%b expected tx=1 done=0 (cycle %0d)", tx, tx_done, cyc);
                end
            end
        end
    end

    task automatic send(input logic [DB-1:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) begin
            compared++; failed++;
            $display("FAIL send_timeout: tx_ready got %b expected 1 within 3000 clk", tx_ready);
        end else begin
            tx_start = 1'b1; tx_data = d; exp_q.push_back(d); acc_cyc = cyc;
            @(negedge clk);
            tx_start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((tx_busy !== 1'b0 || in_frame) && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) begin
            compared++; failed++;
            $display("FAIL idle_timeout: tx_busy got %b expected 0 within 5000 clk", tx_busy);
        end
    endtask

    task automatic wait_frame();
        int t = 0;
        while (!in_frame && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            compared++; failed++;
            $display("FAIL frame_timeout: no frame start got within 100 clk expected one");
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation got no finish expected before 60000 clk");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nd;
        tbl[0] = '{8'h55, 16'd4, 1'b0, 40, 44};
        tbl[1] = '{8'hFF, 16'd0, 1'b1, 11, 12};
        tbl[2] = '{8'h00, 16'd1, 1'b0, 10, 11};
        tbl[3] = '{8'h81, 16'd3, 1'b1, 33, 36};
        tbl[4] = '{8'hA5, 16'd2, 1'b0, 20, 22};
        tbl[5] = '{8'h3C, 16'd5, 1'b1, 55, 60};

        repeat (10) begin @(negedge clk); tx_start = ~tx_start; tx_data = 8'h5A; end
        @(negedge clk);
        tx_start = 1'b0;
        chk("rst_tx", tx, 1); chk("rst_ready", tx_ready, 1); chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0); chk("rst_overrun", tx_overrun, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_load", tx_busy, 0);

        for (int v = 0; v < 6; v++) begin
            baud_div = tbl[v].div; stop2 = tbl[v].s2;
`ifdef UART_TX_PARITY_EN
            parity_odd = 1'b0;
`endif
            send(tbl[v].d);
            wait_idle();
            chk("start_latency", fall_cyc - acc_cyc, 2);
            chk("frame_len", done_cyc - fall_cyc + 1, (PB != 0) ? tbl[v].len_par : tbl[v].len);
        end

        baud_div = 16'd4; stop2 = 1'b0;
        @(negedge clk);
        done_hist.delete(); fall_hist.delete();
        send(8'hA5);
        send(8'h3C);
        chk("hold_full_ready", tx_ready, 0);
        tx_start = 1'b1; tx_data = 8'h99;
        @(negedge clk);
        tx_start = 1'b0;
        chk("overrun_pulse", tx_overrun, 1);
        @(negedge clk);
        chk("overrun_clear", tx_overrun, 0);
        wait_idle();
        chk("b2b_done_count", done_hist.size(), 2);
        if (done_hist.size() == 2 && fall_hist.size() == 2) begin
            chk("b2b_done_spacing", done_hist[1] - done_hist[0], 40 + 4*PB);
            chk("b2b_no_gap", fall_hist[1] - done_hist[0], 1);
        end

        send(8'h3C);
        wait_frame();
        repeat (10) @(negedge clk);
        baud_div = 16'd7;
        wait_idle();
        chk("baud_change_len", done_cyc - fall_cyc + 1, 40 + 4*PB);
        baud_div = 16'd4;

        send(8'hC3);
        wait_frame();
        repeat (12) @(negedge clk);
        rst = 1'b1; exp_q.delete(); nd = n_done;
        @(negedge clk);
        chk("abort_tx", tx, 1); chk("abort_busy", tx_busy, 0); chk("abort_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_done", n_done - nd, 0);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        send(8'h07);
        wait_idle();
        chk("parity_even", par_tx, 1);
        chk("parity_len", done_cyc - fall_cyc + 1, 44);
        parity_odd = 1'b1;
        send(8'h07);
        wait_idle();
        chk("parity_odd", par_tx, 0);
`endif

        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            baud_div = DW'($urandom_range(0, 5));
            stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
            parity_odd = 1'($urandom_range(0, 1));
`endif
            send(DB'($urandom));
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
